// File: rtl/fc_mac_accumulator.sv
// fc_mac_accumulator
// Dual-lane signed MAC fed by the FC weight ROM. Each valid cycle brings two
// weight/feature pairs; INNEURON/2 pairs are accumulated per output neuron,
// then rounded (half-up), arithmetically shifted by FRAC and saturated to
// OUT_WIDTH. Results leave in neuron order with a frame_done strobe on the
// last neuron of the frame.
//
// Handshake: in_valid qualifies weight_*/feat_* in the cycle it is high; there
// is no ready, so the producer may present a pair on any cycle. result_valid is
// a one-cycle strobe with no backpressure; result/neuron_idx hold until the
// next strobe and the consumer must take every strobe.
module fc_mac_accumulator #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC       = 8,
  parameter int ACC_WIDTH  = 40,
  parameter int OUT_WIDTH  = 16,
  parameter int OUTNEURON  = 10,
  parameter int INNEURON   = 576,
  localparam int IDX_W     = (OUTNEURON > 1) ? $clog2(OUTNEURON) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] weight_a,
  input  logic [DATA_WIDTH-1:0] weight_b,
  input  logic [DATA_WIDTH-1:0] feat_a,
  input  logic [DATA_WIDTH-1:0] feat_b,
  output logic [OUT_WIDTH-1:0]  result,
  output logic                  result_valid,
  output logic [IDX_W-1:0]      neuron_idx,
  output logic                  frame_done
);

  localparam int PAIRS  = INNEURON / 2;
  localparam int PAIR_W = (PAIRS > 1) ? $clog2(PAIRS) : 1;
  localparam int PW     = 2 * DATA_WIDTH;

  localparam logic [PAIR_W-1:0] PAIR_LAST   = PAIR_W'(PAIRS - 1);
  localparam logic [IDX_W-1:0]  NEURON_LAST = IDX_W'(OUTNEURON - 1);

  localparam logic signed [ACC_WIDTH-1:0] HALF    = ACC_WIDTH'(64'sd1 <<< (FRAC - 1));
  localparam logic signed [ACC_WIDTH-1:0] OUT_MAX = ACC_WIDTH'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
  localparam logic signed [ACC_WIDTH-1:0] OUT_MIN = ACC_WIDTH'(-(64'sd1 <<< (OUT_WIDTH - 1)));

  // Input-side position within the frame
  logic [PAIR_W-1:0] pair_cnt;
  logic [IDX_W-1:0]  neuron_cnt;
  logic              first_in;
  logic              last_in;

  // Stage 1: registered products plus the flags that travel with them
  logic                 v1;
  logic                 first1;
  logic                 last1;
  logic [IDX_W-1:0]     idx1;
  logic signed [PW-1:0] p_a;
  logic signed [PW-1:0] p_b;

  // Stage 2: running accumulator; last2 marks a completed neuron in acc
  logic signed [ACC_WIDTH-1:0] pa_ext;
  logic signed [ACC_WIDTH-1:0] pb_ext;
  logic signed [ACC_WIDTH-1:0] sum;
  logic signed [ACC_WIDTH-1:0] acc;
  logic                        last2;
  logic [IDX_W-1:0]            idx2;

  // Stage 3 quantization path
  logic signed [ACC_WIDTH-1:0] rnd_sum;
  logic signed [ACC_WIDTH-1:0] rounded;
  logic [OUT_WIDTH-1:0]        sat_val;

  assign first_in = (pair_cnt == '0);
  assign last_in  = (pair_cnt == PAIR_LAST);

  // Pair and neuron counters advance only on accepted pairs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pair_cnt   <= '0;
      neuron_cnt <= '0;
    end else if (in_valid) begin
      if (last_in) begin
        pair_cnt   <= '0;
        neuron_cnt <= (neuron_cnt == NEURON_LAST) ? '0 : neuron_cnt + IDX_W'(1);
      end else begin
        pair_cnt <= pair_cnt + PAIR_W'(1);
      end
    end
  end

  // Stage 1: multiply both lanes at full precision and tag the pair
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1     <= 1'b0;
      first1 <= 1'b0;
      last1  <= 1'b0;
      idx1   <= '0;
      p_a    <= '0;
      p_b    <= '0;
    end else begin
      v1 <= in_valid;
      if (in_valid) begin
        first1 <= first_in;
        last1  <= last_in;
        idx1   <= neuron_cnt;
        p_a    <= $signed(weight_a) * $signed(feat_a);
        p_b    <= $signed(weight_b) * $signed(feat_b);
      end
    end
  end

  // Sign-extend both products to accumulator width and add them
  always_comb begin
    pa_ext = {{(ACC_WIDTH - PW){p_a[PW-1]}}, p_a};
    pb_ext = {{(ACC_WIDTH - PW){p_b[PW-1]}}, p_b};
    sum    = pa_ext + pb_ext;
  end

  // Stage 2: first pair loads, later pairs add; bubbles leave acc untouched
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc   <= '0;
      last2 <= 1'b0;
      idx2  <= '0;
    end else begin
      last2 <= v1 && last1;
      if (v1) begin
        acc  <= first1 ? sum : acc + sum;
        idx2 <= idx1;
      end
    end
  end

  // Round half-up, arithmetic shift, then clamp to the output range
  always_comb begin
    rnd_sum = acc + HALF;
    rounded = rnd_sum >>> FRAC;
    if (rounded > OUT_MAX)      sat_val = OUT_MAX[OUT_WIDTH-1:0];
    else if (rounded < OUT_MIN) sat_val = OUT_MIN[OUT_WIDTH-1:0];
    else                        sat_val = rounded[OUT_WIDTH-1:0];
  end

  // Stage 3: capture the finished neuron; acc is read before any new load lands
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result       <= '0;
      result_valid <= 1'b0;
      neuron_idx   <= '0;
      frame_done   <= 1'b0;
    end else begin
      result_valid <= last2;
      frame_done   <= last2 && (idx2 == NEURON_LAST);
      if (last2) begin
        result     <= sat_val;
        neuron_idx <= idx2;
      end
    end
  end

endmodule

// File: tb/tb_fc_mac_accumulator.sv
// Bench for fc_mac_accumulator: default-parameter instance for frame, gap,
// saturation and reset scenarios; INNEURON=2 instance for rounding corners.
module tb_fc_mac_accumulator;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic        in_valid = 1'b0;
  logic [15:0] wa = '0, wb = '0, fa = '0, fb = '0;
  logic [15:0] result;
  logic        result_valid;
  logic [3:0]  neuron_idx;
  logic        frame_done;

  logic        s_valid = 1'b0;
  logic [15:0] s_wa = '0, s_wb = '0, s_fa = '0, s_fb = '0;
  logic [15:0] s_result;
  logic        s_result_valid;
  logic [3:0]  s_neuron_idx;
  logic        s_frame_done;

  fc_mac_accumulator dut (
    .clk(clk), .reset(reset), .in_valid(in_valid),
    .weight_a(wa), .weight_b(wb), .feat_a(fa), .feat_b(fb),
    .result(result), .result_valid(result_valid),
    .neuron_idx(neuron_idx), .frame_done(frame_done)
  );

  fc_mac_accumulator #(.INNEURON(2)) dut_small (
    .clk(clk), .reset(reset), .in_valid(s_valid),
    .weight_a(s_wa), .weight_b(s_wb), .feat_a(s_fa), .feat_b(s_fb),
    .result(s_result), .result_valid(s_result_valid),
    .neuron_idx(s_neuron_idx), .frame_done(s_frame_done)
  );

  // ---------------- scoreboard ----------------
  // entry = {frame_done, neuron_idx, result}
  logic [20:0] exp_q[$];
  logic [20:0] s_exp_q[$];
  logic [20:0] e, se;

  int n_checks = 0;
  int n_errors = 0;
  int valid_cnt = 0;
  int last_valid_cyc = 0;
  int last_pair_cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (result_valid) begin
      valid_cnt++;
      last_valid_cyc = cyc;
      check("expected_entry_available", (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("result", {16'd0, result}, {16'd0, e[15:0]});
        check("neuron_idx", {28'd0, neuron_idx}, {28'd0, e[19:16]});
        check("frame_done", {31'd0, frame_done}, {31'd0, e[20]});
      end
    end else if (frame_done) begin
      check("frame_done_without_valid", {31'd0, frame_done}, {31'd0, result_valid});
    end
  end

  always @(negedge clk) begin
    if (s_result_valid) begin
      check("small_entry_available", (s_exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
      if (s_exp_q.size() > 0) begin
        se = s_exp_q.pop_front();
        check("small_result", {16'd0, s_result}, {16'd0, se[15:0]});
        check("small_neuron_idx", {28'd0, s_neuron_idx}, {28'd0, se[19:16]});
        check("small_frame_done", {31'd0, s_frame_done}, {31'd0, se[20]});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_pair(input logic [15:0] w, input logic [15:0] f);
    in_valid = 1'b1;
    wa = w; wb = w; fa = f; fb = f;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    last_pair_cyc = cyc;
  endtask

  task automatic run_neuron(input logic [15:0] w, input logic [15:0] f, input int gap_pct,
                            input logic [15:0] exp_res, input int idx);
    for (int p = 0; p < 288; p++) begin
      if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) idle($urandom_range(1, 2));
      if (p == 287) exp_q.push_back({(idx == 9) ? 1'b1 : 1'b0, 4'(idx), exp_res});
      send_pair(w, f);
    end
  endtask

  task automatic run_frame(input int gap_pct);
    logic [15:0] w;
    logic [15:0] r;
    for (int k = 0; k < 10; k++) begin
      w = 16'(k + 1);
      r = 16'(16'h0240 * (k + 1));
      run_neuron(w, 16'h0100, gap_pct, r, k);
    end
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check(tag, exp_q.size(), 0);
  endtask

  task automatic s_send(input logic [15:0] w, input logic [15:0] f,
                        input logic [15:0] exp_res, input int idx);
    s_exp_q.push_back({1'b0, 4'(idx), exp_res});
    s_valid = 1'b1;
    s_wa = w; s_fa = f; s_wb = 16'h0000; s_fb = 16'h0000;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  int snap;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_result", {16'd0, result}, 32'd0);
    check("reset_result_valid", {31'd0, result_valid}, 32'd0);
    check("reset_neuron_idx", {28'd0, neuron_idx}, 32'd0);
    check("reset_frame_done", {31'd0, frame_done}, 32'd0);
    reset = 1'b0;
    idle(2);

    // single neuron: 288 pairs of 1 x 1.0 -> 2.25, latency check
    run_neuron(16'h0001, 16'h0100, 0, 16'h0240, 0);
    idle(6);
    check("single_neuron_strobes", valid_cnt, 1);
    check("latency_edges", last_valid_cyc - last_pair_cyc, 2);

    // remainder of the frame, back to back
    for (int k = 1; k < 10; k++)
      run_neuron(16'(k + 1), 16'h0100, 0, 16'(16'h0240 * (k + 1)), k);
    drain("drain_clean_frame");

    // same frame with random idle gaps; starts again at neuron 0
    run_frame(40);
    drain("drain_gap_frame");

    // saturation both directions
    run_neuron(16'h0100, 16'h0100, 0, 16'h7FFF, 0);
    run_neuron(16'hFF00, 16'h0100, 0, 16'h8000, 1);
    run_neuron(16'h0003, 16'h0100, 0, 16'h06C0, 2);
    // partial neuron 3, then reset
    for (int p = 0; p < 100; p++) send_pair(16'h0004, 16'h0100);
    drain("drain_before_reset");
    reset = 1'b1;
    #2;
    check("midreset_result", {16'd0, result}, 32'd0);
    check("midreset_result_valid", {31'd0, result_valid}, 32'd0);
    check("midreset_neuron_idx", {28'd0, neuron_idx}, 32'd0);
    idle(3);
    reset = 1'b0;
    snap = valid_cnt;
    idle(8);
    check("post_reset_quiet", valid_cnt - snap, 0);
    run_frame(0);
    drain("drain_post_reset_frame");

    // rounding corners on the INNEURON=2 instance
    s_send(16'h0001, 16'h0080, 16'h0001, 0);
    s_send(16'h0001, 16'h007F, 16'h0000, 1);
    s_send(16'hFFFF, 16'h0080, 16'h0000, 2);
    for (int i = 0; i < 20 && s_exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check("drain_small", s_exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #3_000_000;
    n_errors++;
    $display("FAIL timeout: got no completion expected finish before 3000000");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
